orv64_clkg_ctrl: RTL and testbench
==================================

// Module: orv64_clkg_ctrl
// PURPOSE
//   Idle-driven clock-gating controller for ORV64 functional domains (e.g. FPU, MUL/DIV, VPU, L1 fill).
//   One FSM per domain, each driving the en pin of that domain's orv64_clk_gating cell.
//   - Gates a domain after a programmable run of consecutive idle cycles.
//   - Re-enables the clock on a wake request or busy.
//   - Holds the domain not-ready for a fixed settle time before handing it back to the pipeline.
// PARAMETERS
//   N_DOM      4  number of gated domains
//   IDLE_CNT_W 6  width of idle threshold/counter
//   WAKE_LAT   2  cycles from clk_en rise to dom_ready rise; legal range 1..15
// PORTS
//   clk              in   1           core clock (ungated)
//   rstn             in   1           async active-low reset
//   cfg_en           in   1           1 = gating allowed; 0 = wake/keep every domain on
//   cfg_idle_thresh  in   IDLE_CNT_W  idle threshold T (sampled every cycle)
//   tst_en           in   1           scan/test: forces all dom_clk_en high; does not affect the FSMs
//   dom_busy         in   N_DOM       domain has work in flight
//   dom_wake_req     in   N_DOM       requester needs the domain
//   dom_clk_en       out  N_DOM       to the gating cell en pin
//   dom_ready        out  N_DOM       domain clocked and settled; issue is allowed
//   dom_gated        out  N_DOM       status: domain in OFF
// BEHAVIOUR
//   Per-domain state: RUN, DRAIN, OFF, WAKE.
//   Registers per domain: idle_cnt (IDLE_CNT_W, saturating) and wake_cnt (4b).
//   Outputs and reset:
//   - All outputs decode directly from the state flops: no comb path from dom_busy/dom_wake_req to outputs.
//   - dom_clk_en = (state != OFF) | tst_en.
//   - dom_ready = state is RUN or DRAIN.
//   - dom_gated = state is OFF.
//   - Reset (async, rstn=0): state=RUN, idle_cnt=0, wake_cnt=0.
//     dom_clk_en=1, dom_ready=1, dom_gated=0 immediately.
//   - Reset mid-WAKE or mid-OFF returns to RUN with no settle wait.
//   Let idle = cfg_en & ~dom_busy & ~dom_wake_req.
//   RUN:
//   - idle -> DRAIN, idle_cnt=1.
//   - Otherwise stay, idle_cnt=0.
//   DRAIN:
//   - ~idle -> RUN, idle_cnt=0.
//   - Else if idle_cnt >= T -> OFF.
//   - Else idle_cnt += 1 (saturates at all-ones).
//   - Net effect: OFF is entered after max(T,1)+1 consecutive idle cycles.
//   - dom_clk_en falls the cycle after the last idle sample.
//   OFF:
//   - dom_busy | dom_wake_req | ~cfg_en -> WAKE, wake_cnt=0.
//   - A request sampled at cycle t gives dom_clk_en=1 at t+1.
//   WAKE:
//   - dom_clk_en=1, dom_ready=0.
//   - wake_cnt += 1; when wake_cnt == WAKE_LAT-1 -> RUN.
//   - dom_ready=1 exactly WAKE_LAT cycles after dom_clk_en rose.
//   - Inputs are ignored during WAKE; the sequence never aborts back to OFF.
//   Handshake:
//   - A requester holds dom_wake_req until it samples dom_ready=1.
//   - A request arriving in DRAIN aborts the drain the same edge and never drops dom_ready.
//   Simultaneous and boundary cases:
//   - Domains are fully independent; any mix of states is legal.
//   - cfg_en 1->0 forces DRAIN->RUN and OFF->WAKE on the next edge, for all domains at once.
//   - T changing during DRAIN takes effect on the next compare.
//   - T=0 behaves as T=1.
//   - tst_en toggling never alters state, idle_cnt or dom_ready.
// TESTING
//   1. Reset: rstn=0 with inputs at X -> dom_clk_en=4'hF, dom_ready=4'hF, dom_gated=0, asserted asynchronously.
//   2. T=4, dom0 idle from cycle 0 -> dom_clk_en[0]=0 at cycle 5; dom_gated[0]=1 at cycle 5.
//   3. dom0 in OFF, wake_req at cycle t, WAKE_LAT=2 -> clk_en[0]=1 at t+1, dom_ready[0]=1 at t+3.
//   4. T=8, busy pulse after 6 idle cycles -> back to RUN, never gated; dom_ready stays 1 throughout.
//   5. All domains OFF, cfg_en->0 -> all clk_en=1 next cycle, all ready WAKE_LAT later; tst_en=1 in OFF -> clk_en=1, dom_ready stays 0.
//   6. rstn pulsed during WAKE (wake_cnt=1) -> RUN, dom_ready=1 immediately; T=0 -> gating after 2 idle cycles.

Source files
------------

// File: rtl/orv64_clkg_ctrl.sv
// Idle-driven clock-gating controller: one RUN/DRAIN/OFF/WAKE FSM per functional domain,
// each driving the enable of that domain's clock-gating cell plus ready/gated status.
module orv64_clkg_ctrl #(
  parameter int N_DOM      = 4,
  parameter int IDLE_CNT_W = 6,
  parameter int WAKE_LAT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_en,
  input  logic [IDLE_CNT_W-1:0] i_cfg_idle_thresh,
  input  logic                  i_tst_en,
  input  logic [N_DOM-1:0]      i_dom_busy,
  input  logic [N_DOM-1:0]      i_dom_wake_req,
  output logic [N_DOM-1:0]      o_dom_clk_en,
  output logic [N_DOM-1:0]      o_dom_ready,
  output logic [N_DOM-1:0]      o_dom_gated
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_OFF   = 2'd2,
    S_WAKE  = 2'd3
  } state_e;

  localparam logic [3:0]            W_WAKE_LAST = 4'(WAKE_LAT - 1);
  localparam logic [IDLE_CNT_W-1:0] W_IDLE_SAT  = '1;

  for (genvar g = 0; g < N_DOM; g++) begin : g_dom
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [IDLE_CNT_W-1:0]   r_idle_cnt;
    logic [IDLE_CNT_W-1:0]   w_idle_cnt_nxt;
    logic [3:0]              r_wake_cnt;
    logic [3:0]              w_wake_cnt_nxt;
    logic                    w_idle;

    assign w_idle = i_cfg_en & ~i_dom_busy[g] & ~i_dom_wake_req[g];

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_state    <= S_RUN;
        r_idle_cnt <= '0;
        r_wake_cnt <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_idle_cnt <= w_idle_cnt_nxt;
        r_wake_cnt <= w_wake_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_idle_cnt_nxt = r_idle_cnt;
      w_wake_cnt_nxt = r_wake_cnt;
      case (r_state)
        S_RUN: begin
          if (w_idle) begin
            w_state_nxt    = S_DRAIN;
            w_idle_cnt_nxt = IDLE_CNT_W'(1);
          end else begin
            w_idle_cnt_nxt = '0;
          end
        end
        S_DRAIN: begin
          // A threshold of 0 acts as 1 because idle_cnt is already 1 on entry.
          if (!w_idle) begin
            w_state_nxt    = S_RUN;
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt >= i_cfg_idle_thresh) begin
            w_state_nxt = S_OFF;
          end else if (r_idle_cnt != W_IDLE_SAT) begin
            w_idle_cnt_nxt = r_idle_cnt + IDLE_CNT_W'(1);
          end
        end
        S_OFF: begin
          if (!w_idle) begin
            w_state_nxt    = S_WAKE;
            w_wake_cnt_nxt = '0;
          end
        end
        S_WAKE: begin
          // Settle sequence is committed once started; inputs are not looked at.
          w_wake_cnt_nxt = r_wake_cnt + 4'd1;
          if (r_wake_cnt == W_WAKE_LAST) begin
            w_state_nxt    = S_RUN;
            w_idle_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end

    assign o_dom_clk_en[g] = (r_state != S_OFF) | i_tst_en;
    assign o_dom_ready[g]  = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign o_dom_gated[g]  = (r_state == S_OFF);
  end

endmodule

// File: tb/tb_orv64_clkg_ctrl.sv
// Bench for orv64_clkg_ctrl: a per-domain behavioural model (idle-run length, gated flag,
// settle countdown) checked every cycle, plus directed scenarios with literal expectations.
module tb_orv64_clkg_ctrl;
  localparam int N_DOM      = 4;
  localparam int IDLE_CNT_W = 6;
  localparam int WAKE_LAT   = 2;
  localparam int SAT        = (1 << IDLE_CNT_W) - 1;
  localparam int M_READY    = 0;
  localparam int M_OFF      = 1;
  localparam int M_WAKING   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  cfg_en;
  logic [IDLE_CNT_W-1:0] thresh;
  logic                  tst_en;
  logic [N_DOM-1:0]      busy;
  logic [N_DOM-1:0]      wake;
  logic [N_DOM-1:0]      clk_en;
  logic [N_DOM-1:0]      ready;
  logic [N_DOM-1:0]      gated;

  int vectors     = 0;
  int miscompares = 0;

  int mode  [N_DOM] = '{default: 0};
  int run   [N_DOM] = '{default: 0};
  int wleft [N_DOM] = '{default: 0};

  orv64_clkg_ctrl #(
    .N_DOM      (N_DOM),
    .IDLE_CNT_W (IDLE_CNT_W),
    .WAKE_LAT   (WAKE_LAT)
  ) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_cfg_en          (cfg_en),
    .i_cfg_idle_thresh (thresh),
    .i_tst_en          (tst_en),
    .i_dom_busy        (busy),
    .i_dom_wake_req    (wake),
    .o_dom_clk_en      (clk_en),
    .o_dom_ready       (ready),
    .o_dom_gated       (gated)
  );

  always #5 clk = ~clk;

  // Model: a domain gates once it has seen more than max(T,1) consecutive idle samples,
  // and becomes ready again WAKE_LAT cycles after its clock returns.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < N_DOM; d++) begin
        mode[d]  = M_READY;
        run[d]   = 0;
        wleft[d] = 0;
      end
    end else begin
      for (int d = 0; d < N_DOM; d++) begin
        bit idle;
        int seen;
        idle = (cfg_en === 1'b1) && (busy[d] === 1'b0) && (wake[d] === 1'b0);
        seen = (run[d] > SAT) ? SAT : run[d];
        if (mode[d] == M_READY) begin
          if (!idle) run[d] = 0;
          else if (run[d] > 0 && seen >= int'(thresh)) mode[d] = M_OFF;
          else run[d] = run[d] + 1;
        end else if (mode[d] == M_OFF) begin
          if (!idle) begin
            mode[d]  = M_WAKING;
            wleft[d] = WAKE_LAT;
          end
        end else begin
          wleft[d] = wleft[d] - 1;
          if (wleft[d] == 0) begin
            mode[d] = M_READY;
            run[d]  = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N_DOM-1:0] e_clk, e_rdy, e_gat;
    for (int d = 0; d < N_DOM; d++) begin
      e_clk[d] = (mode[d] != M_OFF) ? 1'b1 : tst_en;
      e_rdy[d] = (mode[d] == M_READY);
      e_gat[d] = (mode[d] == M_OFF);
    end
    vectors += 3;
    if (clk_en !== e_clk) begin
      miscompares++;
      $display("FAIL model_clk_en t=%0t: got %h want %h", $time, clk_en, e_clk);
    end
    if (ready !== e_rdy) begin
      miscompares++;
      $display("FAIL model_ready t=%0t: got %h want %h", $time, ready, e_rdy);
    end
    if (gated !== e_gat) begin
      miscompares++;
      $display("FAIL model_gated t=%0t: got %h want %h", $time, gated, e_gat);
    end
  end

  task automatic lit(input string nm, input logic [N_DOM-1:0] act, input logic [N_DOM-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rstn   = 1'b0;
    cfg_en = 1'bx;
    thresh = 'x;
    tst_en = 1'bx;
    busy   = 'x;
    wake   = 'x;
    #3;
    lit("reset_clk_en", clk_en, 4'hF);
    lit("reset_ready",  ready,  4'hF);
    lit("reset_gated",  gated,  4'h0);

    @(negedge clk);
    cfg_en = 1'b1; thresh = 6'd63; tst_en = 1'b0; busy = 4'hF; wake = 4'h0;
    #1 rstn = 1'b1;
    tick(2);

    // dom0 idle from cycle 0 with T=4: gated after 5 idle samples
    thresh = 6'd4; busy = 4'hE;
    tick(4);
    lit("t4_still_on", clk_en, 4'hF);
    tick(1);
    lit("t4_clk_off", clk_en, 4'hE);
    lit("t4_gated",   gated,  4'h1);
    lit("t4_notrdy",  ready,  4'hE);

    // wake request while OFF: clock next cycle, ready WAKE_LAT later
    wake = 4'h1;
    tick(1);
    lit("wake_clk_on", clk_en, 4'hF);
    lit("wake_ready0", ready,  4'hE);
    tick(1);
    lit("wake_ready1", ready,  4'hE);
    tick(1);
    lit("wake_ready2", ready,  4'hF);
    wake = 4'h0; busy = 4'hF;
    tick(1);

    // T=8: busy pulse after 6 idle cycles aborts; then exactly 9 idle samples gate
    thresh = 6'd8; busy = 4'hE;
    tick(6);
    lit("t8_ready_6", ready, 4'hF);
    busy = 4'hF;
    tick(1);
    lit("t8_pulse_gated", gated, 4'h0);
    busy = 4'hE;
    tick(8);
    lit("t8_8idle_gated", gated, 4'h0);
    lit("t8_8idle_ready", ready, 4'hF);
    tick(1);
    lit("t8_9idle_gated", gated, 4'h1);
    busy = 4'hF;
    tick(4);

    // wake request in DRAIN aborts the drain without dropping ready
    thresh = 6'd3; busy = 4'hD;
    tick(2);
    wake = 4'h2;
    tick(1);
    lit("drain_abort_ready", ready, 4'hF);
    tick(3);
    lit("drain_hold_gated", gated, 4'h0);
    wake = 4'h0; busy = 4'hF;
    tick(1);

    // all domains OFF, tst_en overrides clk_en only, then cfg_en drop wakes everyone
    thresh = 6'd4; busy = 4'h0;
    tick(4);
    lit("all_pre_gate", gated, 4'h0);
    tick(1);
    lit("all_gated",  gated,  4'hF);
    lit("all_clkoff", clk_en, 4'h0);
    tst_en = 1'b1;
    #1;
    lit("tst_clk_en", clk_en, 4'hF);
    lit("tst_ready",  ready,  4'h0);
    tick(2);
    lit("tst_gated_hold", gated, 4'hF);
    tst_en = 1'b0; cfg_en = 1'b0;
    tick(1);
    lit("cfg_off_clk_en", clk_en, 4'hF);
    lit("cfg_off_ready0", ready,  4'h0);
    tick(1);
    lit("cfg_off_ready1", ready,  4'h0);
    tick(1);
    lit("cfg_off_ready2", ready,  4'hF);

    // reset pulsed mid-WAKE returns to RUN immediately
    cfg_en = 1'b1;
    tick(5);
    lit("pre_rst_gated", gated, 4'hF);
    wake = 4'hF;
    tick(2);
    lit("mid_wake_ready", ready, 4'h0);
    #1 rstn = 1'b0;
    #1;
    lit("async_rst_ready", ready,  4'hF);
    lit("async_rst_clk",   clk_en, 4'hF);
    lit("async_rst_gated", gated,  4'h0);
    wake = 4'h0; busy = 4'hF;
    @(negedge clk);
    #1 rstn = 1'b1;
    tick(1);

    // T=0 behaves as T=1: two idle samples gate
    thresh = 6'd0; busy = 4'h6;
    tick(1);
    lit("t0_one_idle", clk_en, 4'hF);
    tick(1);
    lit("t0_two_idle", clk_en, 4'h6);
    busy = 4'hF;
    tick(3);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      busy   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      wake   = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      cfg_en = ($urandom_range(0, 15) != 0);
      tst_en = ($urandom_range(0, 7) == 0);
      if ((i % 40) == 0) thresh = 6'($urandom_range(0, 5));
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
